stream_arb4: RTL and testbench
==============================

Name: stream_arb4

Overview:
- 4-input round-robin packet arbiter with valid/ready handshakes on every port.
- Drives the 2-bit select of a `mux4` data path and registers the selected beat into a single-entry output stage.
- Sits directly upstream of downstream consumers; `mux4` is its datapath.
- Grant is held for a whole packet: it is locked from the first beat until the beat with `last` set has been accepted.

Parameters:
- N, 8, data width of each input beat and of the output beat.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- in0_data, in1_data, in2_data, in3_data  input  N each  input beats.
- in_valid  input  4  bit i = input i has a beat.
- in_last  input  4  bit i = input i's beat ends its packet.
- in_ready  output  4  bit i = input i's beat is accepted this cycle.
- switch  output  2  select currently applied to the `mux4` datapath.
- out_data  output  N  registered output beat.
- out_valid  output  1  output beat present.
- out_last  output  1  output beat ends its packet.
- out_ready  input  1  downstream accepts the output beat.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_last=0.
  - state=ARB, ptr=3 (so in0 has first priority), owner=0.
  - switch=0, in_ready=0.
- Load condition: can_load = !out_valid || out_ready.
  - The output register loads and drains in the same cycle, giving 1 beat/cycle sustained.
- ARB state, combinational winner selection:
  - Scan inputs in order ptr+1, ptr+2, ptr+3, ptr (mod 4); the first with in_valid set wins.
  - switch = winner; if no input is valid, switch = ptr.
- ARB state, transfer (any in_valid && can_load):
  - in_ready[winner]=1, all other in_ready bits 0.
  - Next cycle: out_data = winner's data, out_last = in_last[winner], out_valid=1.
  - ptr <= winner.
  - If in_last[winner]=0: state <= LOCKED, owner <= winner.
- LOCKED state:
  - switch = owner; only the owner is considered. Other inputs see in_ready=0 even if valid.
  - Transfer when in_valid[owner] && can_load; in_ready[owner]=1.
  - If that beat has last=1: state <= ARB. ptr stays at owner, so the next packet goes to owner+1 first.
- in_ready timing: purely combinational from the state, in_valid, out_valid and out_ready. No in_ready bit is asserted without the matching in_valid bit.
- Output drain:
  - If out_valid && out_ready and there is no new transfer, out_valid <= 0.
  - out_data and out_last hold their values while stalled (out_valid && !out_ready).
- Upstream stability: inputs must hold data, last and valid until ready. The block does not check this.
  - In LOCKED, an owner that deasserts valid mid-packet just stalls; the lock is kept.
- Single-beat packet (last=1 on its first beat): grant is taken and released the same cycle; state stays ARB.
- Reset mid-packet: lock is dropped, pending out_valid is cleared immediately, ptr returns to 3. Upstream is responsible for restarting packets.
- Latency: 1 cycle from input handshake to out_valid.
- Width rules:
  - ptr, owner and switch are 2 bits; mod-4 wrap is the natural 2-bit overflow.
  - Data passes through unmodified at width N.

Decomposition:
- Shared package (`stream_arb_pkg`):
  - state enum {ARB, LOCKED}.
  - Constant NUM_IN=4.
  - Reset constant PTR_RESET=2'd3.
- Sub-module: instantiate `mux4` (parameter N) for the data path, with switch as its select.
  - A second 1-bit `mux4` instance selects last.
- The round-robin winner logic stays in this block.

Test Plan:
- Reset, then in_valid=4'b1111 with all last=1 and out_ready=1 held:
  - Winners go in0,in1,in2,in3,in0; out_data follows; one beat per cycle, no gaps.
- Drive in2 with a 3-beat packet (0xA1,0xA2,0xA3 with last on 0xA3), with in0 valid throughout:
  - Output is 0xA1,0xA2,0xA3 consecutively; in_ready[0]=0 until after 0xA3.
  - in0 granted next cycle.
- Hold out_ready=0 for 3 cycles with out_valid=1, out_data=0x55:
  - out_data stays 0x55; all in_ready=0.
  - When out_ready=1: drain and new load happen in the same cycle.
- Owner in1 deasserts valid mid-packet for 2 cycles while in3 is valid:
  - state stays LOCKED; switch=1; in_ready[3]=0 throughout.
- Assert rst=0 mid-packet with out_valid=1:
  - out_valid=0 immediately (asynchronously); after release, switch=0.
  - With in_valid=4'b1000 at that point, in3 wins with ptr=3 order.
- No in_valid for 5 cycles after a packet from in1:
  - switch=1, out_valid=0.
  - Next request from in0 and in2 simultaneously: in2 wins.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the 4-input round-robin stream arbiter.
package stream_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam int         NUM_IN    = 4;
   localparam logic [1:0] PTR_RESET = 2'd3;

endpackage

// File: rtl/stream_arb4_mux4.sv
// Plain 4:1 multiplexer of width N; the arbiter's datapath.
module mux4 #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_d0,
   input  logic [N-1:0] i_d1,
   input  logic [N-1:0] i_d2,
   input  logic [N-1:0] i_d3,
   input  logic [1:0]   i_sel,
   output logic [N-1:0] o_y
);

   always_comb begin
      o_y = i_d0;
      case (i_sel)
         2'd0:    o_y = i_d0;
         2'd1:    o_y = i_d1;
         2'd2:    o_y = i_d2;
         default: o_y = i_d3;
      endcase
   end

endmodule

// File: rtl/stream_arb4.sv
// 4-input round-robin packet arbiter: grant is locked for a whole packet and the
// selected beat is registered into a single-entry output stage.
module stream_arb4 #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in0_data,
   input  logic [N-1:0] in1_data,
   input  logic [N-1:0] in2_data,
   input  logic [N-1:0] in3_data,
   input  logic [3:0]   in_valid,
   input  logic [3:0]   in_last,
   output logic [3:0]   in_ready,
   output logic [1:0]   switch,
   output logic [N-1:0] out_data,
   output logic         out_valid,
   output logic         out_last,
   input  logic         out_ready
);

   import stream_arb_pkg::*;

   arb_state_t   r_state;
   arb_state_t   w_state_next;
   logic [1:0]   r_ptr;
   logic [1:0]   r_owner;
   logic [N-1:0] r_out_data;
   logic         r_out_last;
   logic         r_out_valid;

   logic         w_can_load;
   logic [1:0]   w_cand [NUM_IN];
   logic [3:0]   w_cand_valid;
   logic [1:0]   w_winner;
   logic         w_any_valid;
   logic [1:0]   w_switch;
   logic         w_xfer;
   logic [N-1:0] w_sel_data;
   logic         w_sel_last;

   assign w_can_load = !r_out_valid || out_ready;

   // Candidate k is ptr+1+k; the 2-bit add wraps naturally so the last one is ptr itself.
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cand
      assign w_cand[gi]       = r_ptr + 2'(gi + 1);
      assign w_cand_valid[gi] = in_valid[w_cand[gi]];
   end

   always_comb begin
      w_winner    = r_ptr;
      w_any_valid = 1'b0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (w_cand_valid[k]) begin
            w_winner    = w_cand[k];
            w_any_valid = 1'b1;
         end
      end
   end

   // Select and handshake are forced idle while reset is held.
   always_comb begin
      w_switch = 2'd0;
      w_xfer   = 1'b0;
      if (rst) begin
         if (r_state == ARB) begin
            w_switch = w_winner;
            w_xfer   = w_any_valid && w_can_load;
         end else begin
            w_switch = r_owner;
            w_xfer   = in_valid[r_owner] && w_can_load;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign in_ready[gi] = w_xfer && (w_switch == 2'(gi));
   end

   mux4 #(.N(N)) u_data_mux (
      .i_d0  (in0_data),
      .i_d1  (in1_data),
      .i_d2  (in2_data),
      .i_d3  (in3_data),
      .i_sel (w_switch),
      .o_y   (w_sel_data)
   );

   mux4 #(.N(1)) u_last_mux (
      .i_d0  (in_last[0]),
      .i_d1  (in_last[1]),
      .i_d2  (in_last[2]),
      .i_d3  (in_last[3]),
      .i_sel (w_switch),
      .o_y   (w_sel_last)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB: begin
            if (w_xfer && !w_sel_last) begin
               w_state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (w_xfer && w_sel_last) begin
               w_state_next = ARB;
            end
         end
         default: w_state_next = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ARB;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ptr only moves on a fresh grant, so after a packet the owner keeps lowest priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr   <= PTR_RESET;
         r_owner <= 2'd0;
      end else if (w_xfer) begin
         if (r_state == ARB) begin
            r_ptr <= w_switch;
         end
         if (!w_sel_last) begin
            r_owner <= w_switch;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_xfer) begin
         r_out_data  <= w_sel_data;
         r_out_last  <= w_sel_last;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign switch    = w_switch;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_arb4.sv
// Randomized and directed check of stream_arb4 against a packet-level round-robin model.
module tb_stream_arb4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in0_data, in1_data, in2_data, in3_data;
   logic [3:0] in_valid, in_last;
   logic [3:0] in_ready;
   logic [1:0] switch;
   logic [7:0] out_data;
   logic       out_valid, out_last;
   logic       out_ready = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   // Upstream sources
   logic [7:0] s_data [4];
   bit         s_valid [4];
   bit         s_last [4];

   // Model state
   int  m_ptr, m_owner, m_od, m_acc;
   bit  m_locked, m_ov, m_ol;
   int  e_sw, e_rdy;
   bit  e_xfer;

   stream_arb4 #(.N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_data  (in0_data),
      .in1_data  (in1_data),
      .in2_data  (in2_data),
      .in3_data  (in3_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .switch    (switch),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void drive();
      in0_data = s_data[0];
      in1_data = s_data[1];
      in2_data = s_data[2];
      in3_data = s_data[3];
      for (int i = 0; i < 4; i++) begin
         in_valid[i] = s_valid[i];
         in_last[i]  = s_last[i];
      end
   endfunction

   function automatic void model_reset();
      m_ptr    = 3;
      m_owner  = 0;
      m_locked = 1'b0;
      m_ov     = 1'b0;
      m_ol     = 1'b0;
      m_od     = 0;
   endfunction

   // Who gets served this cycle, from the round-robin and packet-lock rules.
   function automatic void model_comb();
      bit can_load = !m_ov || out_ready;
      bit found    = 1'b0;
      int w        = m_ptr;
      e_xfer = 1'b0;
      e_sw   = 0;
      e_rdy  = 0;
      if (rst) begin
         if (!m_locked) begin
            for (int k = 1; k <= 4; k++) begin
               int idx = (m_ptr + k) % 4;
               if (!found && s_valid[idx]) begin
                  found = 1'b1;
                  w     = idx;
               end
            end
            e_sw   = w;
            e_xfer = found && can_load;
         end else begin
            e_sw   = m_owner;
            e_xfer = s_valid[m_owner] && can_load;
         end
         if (e_xfer) e_rdy = 1 << e_sw;
      end
   endfunction

   function automatic void model_update();
      if (e_xfer) begin
         m_acc = e_sw;
         m_od  = int'(s_data[e_sw]);
         m_ol  = s_last[e_sw];
         m_ov  = 1'b1;
         if (!m_locked) m_ptr = e_sw;
         if (s_last[e_sw]) begin
            m_locked = 1'b0;
         end else begin
            m_locked = 1'b1;
            m_owner  = e_sw;
         end
         $display("xfer t=%0t in%0d data=%02h last=%0b", $time, e_sw, s_data[e_sw], s_last[e_sw]);
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
   endfunction

   task automatic pre();
      drive();
      #1;
   endtask

   // One clock: compare everything against the model, then advance it across the edge.
   task automatic step();
      drive();
      #1;
      model_comb();
      chk("in_ready", in_ready, e_rdy);
      chk("switch", switch, e_sw);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("out_last", out_last, m_ol);
      @(posedge clk);
      m_acc = -1;
      if (!rst) model_reset();
      else model_update();
      @(negedge clk);
   endtask

   function automatic void clear_src();
      for (int i = 0; i < 4; i++) begin
         s_valid[i] = 1'b0;
         s_last[i]  = 1'b1;
         s_data[i]  = 8'h00;
      end
   endfunction

   initial begin
      model_reset();
      m_acc = -1;
      // Reset with all inputs requesting single-beat packets.
      for (int i = 0; i < 4; i++) begin
         s_valid[i] = 1'b1;
         s_last[i]  = 1'b1;
         s_data[i]  = 8'h10 + 8'(i);
      end
      @(negedge clk);
      pre();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_switch", switch, 0);
      chk("rst_in_ready", in_ready, 0);
      step();
      step();

      // All valid, last=1: in0,in1,in2,in3,in0 back to back.
      rst = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("t1_out_data", out_data, 32'h10 + 32'((k - 1) % 4));
         chk("t1_out_valid", out_valid, 1);
      end

      // Three-beat packet on in2 while in0 keeps requesting.
      clear_src();
      s_valid[0] = 1'b1; s_data[0] = 8'h30;
      s_valid[2] = 1'b1; s_data[2] = 8'hA1; s_last[2] = 1'b0;
      pre(); chk("t2_rdy1", in_ready, 4'b0100);
      step(); chk("t2_beat1", out_data, 8'hA1);
      s_data[2] = 8'hA2;
      pre(); chk("t2_rdy2", in_ready, 4'b0100);
      step(); chk("t2_beat2", out_data, 8'hA2);
      s_data[2] = 8'hA3; s_last[2] = 1'b1;
      pre(); chk("t2_rdy3", in_ready, 4'b0100);
      step(); chk("t2_beat3", out_data, 8'hA3); chk("t2_last3", out_last, 1);
      s_valid[2] = 1'b0;
      pre(); chk("t2_rdy_in0", in_ready, 4'b0001);
      step(); chk("t2_in0", out_data, 8'h30);
      s_valid[0] = 1'b0;

      // Output stall holds data and blocks every input.
      s_valid[1] = 1'b1; s_data[1] = 8'h55;
      pre(); chk("t3_rdy_in1", in_ready, 4'b0010);
      step(); chk("t3_load", out_data, 8'h55);
      s_valid[1] = 1'b0;
      s_valid[3] = 1'b1; s_data[3] = 8'h66;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pre(); chk("t3_stall_rdy", in_ready, 0);
         step(); chk("t3_hold", out_data, 8'h55); chk("t3_hold_v", out_valid, 1);
      end
      out_ready = 1'b1;
      pre(); chk("t3_release_rdy", in_ready, 4'b1000);
      step(); chk("t3_reload", out_data, 8'h66);
      s_valid[3] = 1'b0;
      step(); chk("t3_drained", out_valid, 0);

      // Owner in1 pauses mid-packet while in3 waits.
      s_valid[1] = 1'b1; s_data[1] = 8'h71; s_last[1] = 1'b0;
      s_valid[3] = 1'b1; s_data[3] = 8'h90;
      pre(); chk("t4_grant1", in_ready, 4'b0010);
      step();
      s_valid[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         pre(); chk("t4_pause_sw", switch, 1); chk("t4_pause_rdy", in_ready, 0);
         step();
      end
      s_valid[1] = 1'b1; s_data[1] = 8'h72; s_last[1] = 1'b1;
      pre(); chk("t4_resume", in_ready, 4'b0010);
      step(); chk("t4_end", out_data, 8'h72);
      s_valid[1] = 1'b0;
      pre(); chk("t4_in3", in_ready, 4'b1000);
      step(); chk("t4_in3_data", out_data, 8'h90);
      s_valid[3] = 1'b0;

      // Asynchronous reset in the middle of a packet.
      s_valid[0] = 1'b1; s_data[0] = 8'h81; s_last[0] = 1'b0;
      step(); chk("t5_pending", out_valid, 1);
      #2 rst = 1'b0;
      #1 chk("t5_async_clear", out_valid, 0);
      model_reset();
      @(negedge clk);
      s_valid[0] = 1'b0;
      s_valid[3] = 1'b1; s_data[3] = 8'h93; s_last[3] = 1'b1;
      pre(); chk("t5_rst_sw", switch, 0); chk("t5_rst_rdy", in_ready, 0);
      step();
      rst = 1'b1;
      pre(); chk("t5_sw3", switch, 3); chk("t5_rdy3", in_ready, 4'b1000);
      step(); chk("t5_data", out_data, 8'h93);
      s_valid[3] = 1'b0;

      // Idle after a packet from in1, then in0 and in2 together.
      s_valid[1] = 1'b1; s_data[1] = 8'hB1;
      step();
      s_valid[1] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         pre(); chk("t6_idle_sw", switch, 1);
         step(); chk("t6_idle_v", out_valid, 0);
      end
      s_valid[0] = 1'b1; s_data[0] = 8'hC0;
      s_valid[2] = 1'b1; s_data[2] = 8'hC2;
      pre(); chk("t6_rdy2", in_ready, 4'b0100); chk("t6_sw2", switch, 2);
      step(); chk("t6_data", out_data, 8'hC2);

      // Random traffic with legal upstream behaviour.
      clear_src();
      for (int c = 0; c < 600; c++) begin
         out_ready = (($urandom % 4) != 0);
         step();
         for (int i = 0; i < 4; i++) begin
            if (m_acc == i) begin
               s_valid[i] = (($urandom % 4) != 0);
               s_data[i]  = 8'($urandom);
               s_last[i]  = (($urandom % 3) == 0);
            end else if (!s_valid[i]) begin
               s_valid[i] = 1'($urandom % 2);
               s_data[i]  = 8'($urandom);
               s_last[i]  = (($urandom % 3) == 0);
            end
         end
         if (c == 300) begin
            #2 rst = 1'b0;
            #1 chk("rnd_async_clear", out_valid, 0);
            model_reset();
            @(negedge clk);
            step();
            rst = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
